// File: rtl/seq_mult_pkg.sv
// +----------------------------------------------------------------------------
// | mult_pkg : shared types and sizing helpers for the sequential multiplier
// | Rev 1.0  : initial release
// +----------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_CNT_W = $clog2(MAX_WIDTH + 1);

    // The iteration counter must be able to hold WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_if.sv
// +----------------------------------------------------------------------------
// | seq_mult_if : start/busy/done handshake and operand/product bus
// | Rev 1.0     : initial release
// +----------------------------------------------------------------------------
`default_nettype none

interface seq_mult_if
    import mult_pkg::*;
#(
    parameter int WIDTH = 3
);
    logic                         start;
    logic                         signed_mode;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
    logic                         busy;
    logic                         done;
    logic [prod_width(WIDTH)-1:0] p;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, p
    );
endinterface

`default_nettype wire

// File: rtl/seq_mult.sv
// +----------------------------------------------------------------------------
// | seq_mult : WIDTH-generic shift-and-add multiplier, optional signed mode
// | Rev 1.0  : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seq_mult_if.slave  bus
);

    localparam int              PW        = prod_width(WIDTH);
    localparam int              CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] ma_q;
    logic [WIDTH-1:0] mb_q;
    logic [WIDTH-1:0] acc_q;
    logic             neg_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    p_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mb_d;
    logic [PW-1:0]    prod_d;
    logic [PW-1:0]    p_d;
    logic [WIDTH-1:0] ma_in_d;
    logic [WIDTH-1:0] mb_in_d;
    logic             neg_in_d;

    // One add/shift step; {acc, mb} holds the growing product once mb drains.
    always_comb begin
        sum_d  = {1'b0, acc_q} + (mb_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});
        acc_d  = sum_d[WIDTH:1];
        mb_d   = {sum_d[0], mb_q[WIDTH-1:1]};
        prod_d = {acc_d, mb_d};
        p_d    = neg_q ? ({PW{1'b0}} - prod_d) : prod_d;
    end

    // Magnitudes are taken as WIDTH-bit unsigned, so the most negative value maps cleanly.
    always_comb begin
        neg_in_d = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        ma_in_d  = (bus.signed_mode && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
        mb_in_d  = (bus.signed_mode && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        ma_q    <= ma_in_d;
                        mb_q    <= mb_in_d;
                        neg_q   <= neg_in_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    mb_q  <= mb_d;
                    cnt_q <= cnt_q + CW'(1);
                    // The final iteration and the sign fix-up share one edge.
                    if (cnt_q == LAST_ITER) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        p_q     <= p_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// +----------------------------------------------------------------------------
// | tb_seq_mult : directed and random checks of seq_mult at WIDTH=3 and WIDTH=8
// | Rev 1.0     : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_seq_mult;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    logic [15:0] q3[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_mult_if #(.WIDTH(3)) if3 ();
    seq_mult_if #(.WIDTH(8)) if8 ();

    seq_mult #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sm,
                         input logic [7:0] a, input logic [7:0] b);
        if (w == 3) begin
            if3.start = st; if3.signed_mode = sm; if3.a = a[2:0]; if3.b = b[2:0];
        end else begin
            if8.start = st; if8.signed_mode = sm; if8.a = a;      if8.b = b;
        end
    endtask

    function automatic logic [15:0] p_of(input int w);
        return (w == 3) ? {10'b0, if3.p} : if8.p;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 3) ? if3.busy : if8.busy;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 3) ? if3.done : if8.done;
    endfunction

    function automatic logic [15:0] model(input int w, input logic sm,
                                          input logic [7:0] a, input logic [7:0] b);
        int     mask;
        int     sa;
        int     sb;
        longint pr;
        mask = (1 << w) - 1;
        sa   = int'(a) & mask;
        sb   = int'(b) & mask;
        if (sm && (((sa >> (w - 1)) & 1) == 1)) sa = sa - (1 << w);
        if (sm && (((sb >> (w - 1)) & 1) == 1)) sb = sb - (1 << w);
        pr = longint'(sa) * longint'(sb);
        return 16'(pr & longint'((1 << (2 * w)) - 1));
    endfunction

    // Starts one multiply from IDLE or DONE and returns at the negedge showing done.
    task automatic issue(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input bit glitch, input string tag, output int done_cyc);
        int          lat;
        int          busy_n;
        logic [15:0] held;
        logic [15:0] exp;
        exp = model(w, sm, a, b);
        if (w == 3) q3.push_back(exp); else q8.push_back(exp);
        held = p_of(w);
        drive(w, 1'b1, sm, a, b);
        @(negedge clk);
        drive(w, 1'b0, ~sm, ~a, b ^ 8'h5a);
        lat    = 0;
        busy_n = 0;
        while (done_of(w) !== 1'b1 && lat < w + 4) begin
            if (busy_of(w) === 1'b1) busy_n++;
            if (lat == 0) check({tag, " p_hold"}, {48'b0, p_of(w)}, {48'b0, held});
            if (glitch && lat == 1) drive(w, 1'b1, sm, ~a, ~b);
            else                    drive(w, 1'b0, ~sm, ~a, b ^ 8'h5a);
            @(negedge clk);
            lat++;
        end
        done_cyc = cyc;
        check({tag, " latency"}, 64'(lat), 64'(w));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(w));
        check({tag, " busy_in_done"}, {63'b0, busy_of(w)}, 64'd0);
        if (w == 3) begin
            if (q3.size() > 0) exp = q3.pop_front(); else exp = 16'hxxxx;
        end else begin
            if (q8.size() > 0) exp = q8.pop_front(); else exp = 16'hxxxx;
        end
        check({tag, " product"}, {48'b0, p_of(w)}, {48'b0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          dc;
        int          prev_dc;
        int          extra;
        logic [2:0]  ua[5];
        logic [2:0]  ub[5];
        logic [2:0]  sa[4];
        logic [2:0]  sb[4];
        logic [7:0]  ra;
        logic [7:0]  rb;

        ua = '{3'd6, 3'd2, 3'd7, 3'd4, 3'd7};
        ub = '{3'd1, 3'd7, 3'd3, 3'd4, 3'd7};
        sa = '{3'b111, 3'b100, 3'b100, 3'b000};
        sb = '{3'b011, 3'b100, 3'b011, 3'b100};

        drive(3, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 1'b0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        check("rst busy3", {63'b0, if3.busy}, 64'd0);
        check("rst done3", {63'b0, if3.done}, 64'd0);
        check("rst p3",    {58'b0, if3.p},    64'd0);
        check("rst busy8", {63'b0, if8.busy}, 64'd0);
        check("rst done8", {63'b0, if8.done}, 64'd0);
        check("rst p8",    {48'b0, if8.p},    64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3, 1'b0, 8'd3, 8'd5, 1'b0, "u3x5", dc);
        check("u3x5 p_exact", {58'b0, if3.p}, 64'b001111);
        @(negedge clk);
        check("u3x5 single_pulse", {63'b0, if3.done}, 64'd0);

        // Back-to-back: each call starts in the DONE cycle of the previous one.
        prev_dc = 0;
        for (int i = 0; i < 5; i++) begin
            issue(3, 1'b0, {5'b0, ua[i]}, {5'b0, ub[i]}, 1'b0, $sformatf("b2b%0d", i), dc);
            if (i > 0) check($sformatf("b2b%0d spacing", i), 64'(dc - prev_dc), 64'd4);
            prev_dc = dc;
        end
        @(negedge clk);
        check("b2b idle_done", {63'b0, if3.done}, 64'd0);
        check("b2b idle_busy", {63'b0, if3.busy}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            issue(3, 1'b1, {5'b0, sa[i]}, {5'b0, sb[i]}, 1'b0, $sformatf("s3_%0d", i), dc);
            @(negedge clk);
        end

        issue(3, 1'b0, 8'd3, 8'd5, 1'b1, "glitch", dc);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (if3.done === 1'b1) extra++;
        end
        check("glitch extra_done", 64'(extra), 64'd0);
        check("glitch p_kept", {58'b0, if3.p}, 64'd15);

        // Abort in the second RUN cycle.
        drive(3, 1'b1, 1'b0, 8'd7, 8'd7);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", {63'b0, if3.busy}, 64'd0);
        check("abort done", {63'b0, if3.done}, 64'd0);
        check("abort p",    {58'b0, if3.p},    64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (if3.done === 1'b1 || if3.busy === 1'b1) extra++;
        end
        check("abort quiet", 64'(extra), 64'd0);
        issue(3, 1'b0, 8'd6, 8'd7, 1'b0, "post_rst", dc);
        @(negedge clk);

        issue(8, 1'b0, 8'hFF, 8'hFF, 1'b0, "u8 max", dc);
        issue(8, 1'b1, 8'h80, 8'h80, 1'b0, "s8 minmin", dc);
        issue(8, 1'b1, 8'h80, 8'h7F, 1'b0, "s8 minmax", dc);
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue(8, 1'b0, ra, rb, 1'b0, $sformatf("u8r%0d", i), dc);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue(8, 1'b1, ra, rb, 1'b0, $sformatf("s8r%0d", i), dc);
            if ((i % 7) == 0) @(negedge clk);
        end
        @(negedge clk);
        check("w8 final_idle", {63'b0, if8.busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
